// File: rtl/bb8051_xdata_ctrl_pkg.sv
// Shared BB8051 XDATA definitions: controller state encoding and bus reset/error values.
package bb8051_xdata_ctrl_pkg;

    typedef enum logic [1:0] {
        XstIdle   = 2'd0,
        XstSetup  = 2'd1,
        XstAccess = 2'd2,
        XstDone   = 2'd3
    } xst_e;

    localparam logic [15:0] BB8051_RST_XADDR     = 16'h0000;
    localparam logic [7:0]  BB8051_XDATA_ERR_VAL = 8'hFF;
    localparam logic [7:0]  BB8051_RST_XWDATA    = 8'h00;

    // MOVX @DPTR uses the full DPTR; MOVX @Ri pages through P2.
    function automatic logic [15:0] xdata_addr(
        input logic       use_dptr,
        input logic [7:0] dph,
        input logic [7:0] dpl,
        input logic [7:0] p2,
        input logic [7:0] ri
    );
        return use_dptr ? {dph, dpl} : {p2, ri};
    endfunction

endpackage

// File: rtl/bb8051_xdata_ctrl.sv
// MOVX external data-memory controller: latches the address at accept, then runs a
// strobe/ack cycle with a minimum strobe width and a timeout abort.
module bb8051_xdata_ctrl
    import bb8051_xdata_ctrl_pkg::*;
#(
    parameter int unsigned STB_MIN = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_use_dptr,
    input  logic [7:0]  dptr_h,
    input  logic [7:0]  dptr_l,
    input  logic [7:0]  p2_data,
    input  logic [7:0]  ri_data,
    input  logic [7:0]  req_wdata,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic [15:0] x_addr,
    output logic [7:0]  x_wdata,
    output logic        x_we,
    output logic        x_stb,
    input  logic [7:0]  x_rdata,
    input  logic        x_ack
);

    localparam logic [7:0] StbLast = 8'(STB_MIN - 1);
    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    xst_e       state;
    logic [7:0] cnt;
    logic       complete;
    logic       timed_out;

    // An ack only counts once the strobe has been held for STB_MIN cycles.
    assign complete  = x_ack && (cnt >= StbLast);
    assign timed_out = (cnt == TmoLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= XstIdle;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_data   <= BB8051_XDATA_ERR_VAL;
            x_addr    <= BB8051_RST_XADDR;
            x_wdata   <= BB8051_RST_XWDATA;
            x_we      <= 1'b0;
            x_stb     <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                XstIdle: begin
                    if (req_valid) begin
                        x_addr    <= xdata_addr(req_use_dptr, dptr_h, dptr_l, p2_data, ri_data);
                        x_we      <= req_we;
                        x_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= XstSetup;
                    end
                end
                XstSetup: begin
                    x_stb <= 1'b1;
                    cnt   <= 8'd0;
                    state <= XstAccess;
                end
                XstAccess: begin
                    // Completion takes priority over a coincident timeout.
                    if (complete) begin
                        x_stb <= 1'b0;
                        done  <= 1'b1;
                        if (!x_we) begin
                            rd_data <= x_rdata;
                        end
                        state <= XstDone;
                    end else if (timed_out) begin
                        x_stb <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        if (!x_we) begin
                            rd_data <= BB8051_XDATA_ERR_VAL;
                        end
                        state <= XstDone;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XstDone: begin
                    req_ready <= 1'b1;
                    state     <= XstIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bb8051_xdata_ctrl.sv
// Self-checking bench for bb8051_xdata_ctrl: directed MOVX cases plus random accesses
// checked against a per-access timing/data model.
module tb_bb8051_xdata_ctrl;

    localparam int STB_MIN = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_use_dptr;
    logic [7:0]  dptr_h;
    logic [7:0]  dptr_l;
    logic [7:0]  p2_data;
    logic [7:0]  ri_data;
    logic [7:0]  req_wdata;
    logic        done;
    logic        err;
    logic [7:0]  rd_data;
    logic [15:0] x_addr;
    logic [7:0]  x_wdata;
    logic        x_we;
    logic        x_stb;
    logic [7:0]  x_rdata;
    logic        x_ack;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_rd;

    bb8051_xdata_ctrl #(
        .STB_MIN (STB_MIN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_use_dptr (req_use_dptr),
        .dptr_h       (dptr_h),
        .dptr_l       (dptr_l),
        .p2_data      (p2_data),
        .ri_data      (ri_data),
        .req_wdata    (req_wdata),
        .done         (done),
        .err          (err),
        .rd_data      (rd_data),
        .x_addr       (x_addr),
        .x_wdata      (x_wdata),
        .x_we         (x_we),
        .x_stb        (x_stb),
        .x_rdata      (x_rdata),
        .x_ack        (x_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One MOVX access. Entered after a negedge; returns at the negedge of the IDLE cycle
    // following DONE. mask[i] = ack driven during the i-th strobe cycle.
    task automatic run_access(input string tag, input bit use_dptr, input bit we,
                              input logic [7:0] dh, input logic [7:0] dl,
                              input logic [7:0] p2, input logic [7:0] ri,
                              input logic [7:0] wd, input logic [7:0] rdat,
                              input logic [TIMEOUT-1:0] mask, input bit hold_valid,
                              input bit expect_no_wait);
        int          wait_cyc = 0;
        int          exp_len = TIMEOUT;
        bit          exp_err = 1'b1;
        logic [15:0] exp_addr;
        int          cyc = 0;
        int          stb_n = 0;
        int          done_cyc = -1;
        int          ready_hi = 0;
        int          addr_bad = 0;
        logic        got_err = 1'b0;

        // Model: first ack at or beyond the minimum strobe width wins, else timeout.
        for (int i = STB_MIN - 1; i < TIMEOUT; i++) begin
            if (mask[i]) begin
                exp_len = i + 1;
                exp_err = 1'b0;
                break;
            end
        end
        exp_addr = use_dptr ? {dh, dl} : {p2, ri};

        while (!req_ready && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (expect_no_wait) check({tag, "_b2b_wait"}, wait_cyc, 0);

        req_valid    = 1'b1;
        req_we       = we;
        req_use_dptr = use_dptr;
        dptr_h       = dh;
        dptr_l       = dl;
        p2_data      = p2;
        ri_data      = ri;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        check({tag, "_addr"}, x_addr, exp_addr);
        check({tag, "_we"}, x_we, we);
        check({tag, "_wdata"}, x_wdata, wd);
        check({tag, "_setup_stb"}, x_stb, 0);

        while (cyc < TIMEOUT + 8) begin
            @(negedge clk);
            cyc++;
            if (!hold_valid) req_valid = 1'b0;
            // Source operands change freely after accept; the latched address must not.
            dptr_h    = 8'($urandom);
            dptr_l    = 8'($urandom);
            p2_data   = 8'($urandom);
            ri_data   = 8'($urandom);
            req_wdata = 8'($urandom);
            req_we    = 1'($urandom);
            if (req_ready) ready_hi++;
            if (done) begin
                done_cyc = cyc;
                got_err  = err;
                x_ack    = 1'b0;
                break;
            end
            if (x_stb) begin
                if (x_addr !== exp_addr || x_we !== we || x_wdata !== wd) addr_bad++;
                x_ack = (stb_n < TIMEOUT) ? mask[stb_n] : 1'b0;
                stb_n++;
            end else begin
                x_ack = 1'b0;
            end
            x_rdata = x_ack ? rdat : 8'($urandom);
        end

        exp_rd = we ? exp_rd : (exp_err ? 8'hFF : rdat);
        check({tag, "_done_cycle"}, done_cyc, exp_len + 2);
        check({tag, "_stb_cycles"}, stb_n, exp_len);
        check({tag, "_err"}, got_err, exp_err);
        check({tag, "_rd_data"}, rd_data, exp_rd);
        check({tag, "_bus_stable"}, addr_bad, 0);
        check({tag, "_busy_ready"}, ready_hi, 0);

        @(negedge clk);
        check({tag, "_post_done"}, {done, err, x_stb}, 3'b000);
        check({tag, "_post_ready"}, req_ready, 1);
        check({tag, "_hold_addr"}, x_addr, exp_addr);
        check({tag, "_hold_wdata"}, x_wdata, wd);
    endtask

    logic [TIMEOUT-1:0] m;

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_use_dptr = 1'b0;
        dptr_h       = 8'h00;
        dptr_l       = 8'h00;
        p2_data      = 8'h00;
        ri_data      = 8'h00;
        req_wdata    = 8'h00;
        x_rdata      = 8'h00;
        x_ack        = 1'b0;
        exp_rd       = 8'hFF;

        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_pulses", {done, err}, 2'b00);
        check("rst_rd_data", rd_data, 8'hFF);
        check("rst_x_addr", x_addr, 16'h0000);
        check("rst_x_wdata", x_wdata, 8'h00);
        check("rst_x_we_stb", {x_we, x_stb}, 2'b00);
        rst = 1'b0;

        // Reset in the middle of an ACCESS strobe.
        @(negedge clk);
        req_valid    = 1'b1;
        req_use_dptr = 1'b1;
        dptr_h       = 8'h55;
        dptr_l       = 8'hAA;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_stb_before", x_stb, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_stb_async", x_stb, 0);
        check("midrst_no_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", req_ready, 1);
        check("midrst_rd_data", rd_data, 8'hFF);
        check("midrst_no_done2", done, 0);

        m = '1;
        run_access("dptr_rd", 1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'hA5, m, 1'b0, 1'b0);

        m = '0;
        m[4] = 1'b1;
        run_access("ri_wr", 1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h7F, 8'h3C, 8'h11, m, 1'b0, 1'b0);

        m = '0;
        m[0] = 1'b1;
        m[3] = 1'b1;
        run_access("early_ack", 1'b1, 1'b0, 8'h40, 8'h02, 8'h00, 8'h00, 8'h00, 8'h6E, m, 1'b0,
                   1'b0);

        m = '0;
        run_access("timeout", 1'b1, 1'b0, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h99, m, 1'b0,
                   1'b0);

        m = '1;
        run_access("b2b_a", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, m, 1'b1, 1'b0);
        run_access("b2b_b", 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hC3, m, 1'b0, 1'b1);

        // Timeout boundary: ack on the final allowed cycle still completes.
        m = '0;
        m[TIMEOUT-1] = 1'b1;
        run_access("last_ack", 1'b0, 1'b0, 8'h00, 8'h00, 8'h12, 8'h9A, 8'h00, 8'h3E, m, 1'b0,
                   1'b0);

        for (int n = 0; n < 16; n++) begin
            m = '0;
            if ($urandom_range(0, 5) != 0) begin
                for (int i = 0; i < TIMEOUT; i++) m[i] = ($urandom_range(0, 7) == 0);
            end
            run_access("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), m,
                       1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
